// File: rtl/boxcar_filter_bank_pkg.sv
// Shared settings for the boxcar filter bank: default widths, channel/window
// defaults and the peak-detector state type.
package boxcar_filter_bank_pkg;

    localparam int SIZE_ADC_DATA      = 12;
    localparam int SIZE_FILTER_DATA   = 14;
    localparam int BOXCAR_NUM_CH      = 4;
    localparam int BOXCAR_WINDOW_LOG2 = 3;
    localparam int BOXCAR_PW_W        = 8;

    typedef enum logic {PK_IDLE, PK_ABOVE} peak_state_t;

endpackage

// File: rtl/boxcar_channel.sv
// One boxcar channel: L-deep delay line, running-sum accumulator and, when
// BOXCAR_PEAK_DETECT_EN is defined, a threshold-crossing peak detector.
module boxcar_channel
    import boxcar_filter_bank_pkg::*;
#(
    parameter int DATA_W      = SIZE_ADC_DATA,
    parameter int WINDOW_LOG2 = BOXCAR_WINDOW_LOG2,
    parameter int OUT_W       = SIZE_FILTER_DATA,
    parameter int PW_W        = BOXCAR_PW_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WINDOW_LOG2-1:0] wr_ptr,
    input  logic [DATA_W-1:0]      x_in,
    input  logic                   s1_valid,
    input  logic                   filt_valid,
    input  logic [OUT_W-1:0]       threshold,
    output logic [OUT_W-1:0]       filtered,
    output logic                   peak_valid,
    output logic [OUT_W-1:0]       peak_value,
    output logic [PW_W-1:0]        peak_width
);

    localparam int L     = 1 << WINDOW_LOG2;
    localparam int ACC_W = DATA_W + WINDOW_LOG2;

    logic [DATA_W-1:0] line_q [L];
    logic [DATA_W-1:0] line_d [L];
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    // Stage 1: capture the new sample and the one it displaces from the window.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        line_d = line_q;
        x_d    = x_q;
        old_d  = old_q;
        if (in_valid) begin
            line_d[wr_ptr] = x_in;
            x_d            = x_in;
            old_d          = line_q[wr_ptr];
        end
    end

    // Intermediate wrap is harmless: the true sum always fits in ACC_W bits.
    always_comb begin
        acc_d = acc_q;
        if (s1_valid) begin
            acc_d = acc_q + ACC_W'(x_q) - ACC_W'(old_q);
        end
    end

    // NOTE: the delay line is reset explicitly so warm-up sums are exact partial sums.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                line_q[i] <= '0;
            end
            x_q   <= '0;
            old_q <= '0;
            acc_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            line_q <= line_d;
            x_q    <= x_d;
            old_q  <= old_d;
            acc_q  <= acc_d;
        end
    end

    if (OUT_W >= ACC_W) begin : g_zext
        assign filtered = OUT_W'(acc_q);
    end else begin : g_trunc
        logic unused_acc_lsbs;
        assign filtered        = acc_q[ACC_W-1 -: OUT_W];
        assign unused_acc_lsbs = ^acc_q[ACC_W-OUT_W-1:0];
    end

`ifdef BOXCAR_PEAK_DETECT_EN
    peak_state_t       state_q, state_d;
    logic [OUT_W-1:0]  max_q, max_d;
    logic [PW_W-1:0]   width_q, width_d;
    logic              peak_valid_q, peak_valid_d;
    logic [OUT_W-1:0]  peak_value_q, peak_value_d;
    logic [PW_W-1:0]   peak_width_q, peak_width_d;

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        width_d      = width_q;
        peak_valid_d = 1'b0;
        peak_value_d = peak_value_q;
        peak_width_d = peak_width_q;
        if (filt_valid) begin
            case (state_q)
                PK_IDLE: begin
                    if (filtered >= threshold) begin
                        state_d = PK_ABOVE;
                        max_d   = filtered;
                        width_d = PW_W'(1);
                    end
                end
                PK_ABOVE: begin
                    if (filtered >= threshold) begin
                        if (filtered > max_q) begin
                            max_d = filtered;
                        end
                        if (width_q != '1) begin
                            width_d = width_q + 1'b1;
                        end
                    end else begin
                        peak_valid_d = 1'b1;
                        peak_value_d = max_q;
                        peak_width_d = width_q;
                        state_d      = PK_IDLE;
                    end
                end
                default: state_d = PK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PK_IDLE;
            max_q        <= '0;
            width_q      <= '0;
            peak_valid_q <= 1'b0;
            peak_value_q <= '0;
            peak_width_q <= '0;
        end else begin
            state_q      <= state_d;
            max_q        <= max_d;
            width_q      <= width_d;
            peak_valid_q <= peak_valid_d;
            peak_value_q <= peak_value_d;
            peak_width_q <= peak_width_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_value = peak_value_q;
    assign peak_width = peak_width_q;
`else
    logic unused_peak_inputs;
    assign unused_peak_inputs = ^{threshold, filt_valid};
    assign peak_valid         = 1'b0;
    assign peak_value         = '0;
    assign peak_width         = '0;
`endif

endmodule

// File: rtl/boxcar_filter_bank.sv
// NUM_CH-channel moving-sum filter with shared write pointer and fill gating.
// Peak detection is built only when BOXCAR_PEAK_DETECT_EN is defined.
module boxcar_filter_bank
    import boxcar_filter_bank_pkg::*;
#(
    parameter int NUM_CH      = BOXCAR_NUM_CH,
    parameter int DATA_W      = SIZE_ADC_DATA,
    parameter int WINDOW_LOG2 = BOXCAR_WINDOW_LOG2,
    parameter int OUT_W       = SIZE_FILTER_DATA,
    parameter int PW_W        = BOXCAR_PW_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [NUM_CH*DATA_W-1:0] input_data,
    input  logic [OUT_W-1:0]        threshold,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] output_data,
    output logic [NUM_CH-1:0]       peak_valid,
    output logic [NUM_CH*OUT_W-1:0] peak_value,
    output logic [NUM_CH*PW_W-1:0]  peak_width
);

    localparam int L      = 1 << WINDOW_LOG2;
    localparam int FILL_W = WINDOW_LOG2 + 1;

    logic [WINDOW_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_full_q, s1_full_d;
    logic                   out_valid_q, out_valid_d;

    // A sample is flagged valid only if it completes (or follows) a full window.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        s1_valid_d  = in_valid;
        s1_full_d   = in_valid && (fill_q >= FILL_W'(L - 1));
        out_valid_d = s1_valid_q && s1_full_q;
        if (in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_W'(L)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_full_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            s1_valid_q  <= s1_valid_d;
            s1_full_q   <= s1_full_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        boxcar_channel #(
            .DATA_W      (DATA_W),
            .WINDOW_LOG2 (WINDOW_LOG2),
            .OUT_W       (OUT_W),
            .PW_W        (PW_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .wr_ptr     (wr_ptr_q),
            .x_in       (input_data[c*DATA_W +: DATA_W]),
            .s1_valid   (s1_valid_q),
            .filt_valid (out_valid_q),
            .threshold  (threshold),
            .filtered   (output_data[c*OUT_W +: OUT_W]),
            .peak_valid (peak_valid[c]),
            .peak_value (peak_value[c*OUT_W +: OUT_W]),
            .peak_width (peak_width[c*PW_W +: PW_W])
        );
    end

endmodule
